// File: rtl/pipe_ctrl_pkg.sv
// Shared icode/stat constants, RNONE and FSM encoding for the Y86-64 pipeline control slice.
package pipe_ctrl_pkg;

  localparam int IRMMOVQ = 4;
  localparam int IMRMOVQ = 5;
  localparam int IOPQ    = 6;
  localparam int IJXX    = 7;
  localparam int ICALL   = 8;
  localparam int IRET    = 9;
  localparam int IPUSHQ  = 10;
  localparam int IPOPQ   = 11;

  localparam int SAOK = 1;
  localparam int SADR = 2;
  localparam int SINS = 3;
  localparam int SHLT = 4;

  // -1 truncates to all ones at whatever register-ID width the user picks
  localparam int RNONE = -1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  function automatic logic is_exc(input int stat);
    return (stat == SADR) || (stat == SINS) || (stat == SHLT);
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable; clears on synchronous active-low reset.
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: classic hazards, dmem wait state with watchdog, sticky halt.
// Optional hazard counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ICODE_W     = 4,
  parameter int REG_W       = 4,
  parameter int STAT_W      = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_Cnd,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  input  logic               dmem_busy,
  output logic               F_stall,
  output logic               D_stall,
  output logic               E_stall,
  output logic               M_stall,
  output logic               W_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_bubble,
  output logic               set_CC,
  output logic               halted,
  output logic               mem_timeout,
  output logic [PERF_W-1:0]  perf_loaduse,
  output logic [PERF_W-1:0]  perf_mispred,
  output logic [PERF_W-1:0]  perf_ret,
  output logic [PERF_W-1:0]  perf_memwait
);

  ctrl_state_e state;
  logic [7:0]  wait_cnt;
  logic        w_exc, m_exc, memop, mem_nr, mem_hold, timeout_hit;
  logic        lu, mp, rt;

  assign w_exc = is_exc(int'(W_stat));
  assign m_exc = is_exc(int'(m_stat));
  assign memop = M_icode inside {ICODE_W'(IRMMOVQ), ICODE_W'(IMRMOVQ), ICODE_W'(ICALL),
                                 ICODE_W'(IRET), ICODE_W'(IPUSHQ), ICODE_W'(IPOPQ)};

  // The cycle dmem_busy drops completes the access, so M must be free to advance then.
  assign mem_nr      = dmem_busy && ((state == ST_MEM_WAIT) || ((state == ST_RUN) && memop));
  assign mem_hold    = mem_nr && !m_exc && !w_exc;
  assign timeout_hit = (state == ST_MEM_WAIT) && dmem_busy && (wait_cnt == 8'(MEM_TIMEOUT));

  assign lu = ((E_icode == ICODE_W'(IMRMOVQ)) || (E_icode == ICODE_W'(IPOPQ))) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB)) && (E_dstM != REG_W'(RNONE));
  assign mp = (E_icode == ICODE_W'(IJXX)) && !e_Cnd;
  assign rt = (D_icode == ICODE_W'(IRET)) || (E_icode == ICODE_W'(IRET)) ||
              (M_icode == ICODE_W'(IRET));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else if (w_exc || timeout_hit) begin
      state <= ST_HALT;
    end else begin
      case (state)
        ST_RUN: begin
          if (memop && dmem_busy && !m_exc) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_busy) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output is defaulted first so no branch can infer a latch.
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    set_CC   = 1'b0;
    halted   = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_bubble = 1'b1;
    end else if (state == ST_HALT) begin
      halted  = 1'b1;
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end else if (mem_hold) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else begin
      // Load/use wins over ret so D is never stalled and bubbled together.
      F_stall  = lu || rt;
      D_stall  = lu;
      D_bubble = mp || (rt && !lu);
      E_bubble = mp || lu;
      M_bubble = m_exc || w_exc;
      W_stall  = w_exc;
      set_CC   = (E_icode == ICODE_W'(IOPQ)) && !M_bubble;
    end
    mem_timeout = rst_n && timeout_hit;
  end

`ifdef PIPE_PERF_CNT_EN
  logic cnt_en, rt_bubble_ev;

  assign cnt_en       = rst_n && (state != ST_HALT);
  assign rt_bubble_ev = rt && !lu && !mem_hold;

  hazard_perf_counter #(.W(PERF_W)) u_cnt_loaduse (
    .clk(clk), .rst_n(rst_n), .en(cnt_en && lu), .count(perf_loaduse)
  );
  hazard_perf_counter #(.W(PERF_W)) u_cnt_mispred (
    .clk(clk), .rst_n(rst_n), .en(cnt_en && mp), .count(perf_mispred)
  );
  hazard_perf_counter #(.W(PERF_W)) u_cnt_ret (
    .clk(clk), .rst_n(rst_n), .en(cnt_en && rt_bubble_ev), .count(perf_ret)
  );
  hazard_perf_counter #(.W(PERF_W)) u_cnt_memwait (
    .clk(clk), .rst_n(rst_n), .en(cnt_en && mem_nr), .count(perf_memwait)
  );
`else
  assign perf_loaduse = '0;
  assign perf_mispred = '0;
  assign perf_ret     = '0;
  assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int T_MAIN  = 5;
  localparam int T_SHORT = 3;
  localparam int PW      = 4;
  localparam int PMAX    = 15;

  // Output vector layout: {F,D,E,M,W stall, D,E,M,W bubble, set_CC, halted, mem_timeout}
  localparam logic [11:0] O_RESET = 12'b00000_1111_000;
  localparam logic [11:0] O_HALT  = 12'b11111_0000_010;
  localparam logic [11:0] O_MEMNR = 12'b11110_0001_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd, dmem_busy;
  logic [2:0] m_stat, W_stat;

  wire [11:0]     a_out, b_out;
  wire [4*PW-1:0] a_perf, b_perf;

  int n_tests = 0;
  int n_fail  = 0;

  bit mh;
  int mw;
  int c_lu, c_mp, c_rt, c_mw;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T_MAIN), .PERF_W(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_busy(dmem_busy),
    .F_stall(a_out[11]), .D_stall(a_out[10]), .E_stall(a_out[9]), .M_stall(a_out[8]),
    .W_stall(a_out[7]), .D_bubble(a_out[6]), .E_bubble(a_out[5]), .M_bubble(a_out[4]),
    .W_bubble(a_out[3]), .set_CC(a_out[2]), .halted(a_out[1]), .mem_timeout(a_out[0]),
    .perf_loaduse(a_perf[15:12]), .perf_mispred(a_perf[11:8]),
    .perf_ret(a_perf[7:4]), .perf_memwait(a_perf[3:0])
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T_SHORT), .PERF_W(PW)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_busy(dmem_busy),
    .F_stall(b_out[11]), .D_stall(b_out[10]), .E_stall(b_out[9]), .M_stall(b_out[8]),
    .W_stall(b_out[7]), .D_bubble(b_out[6]), .E_bubble(b_out[5]), .M_bubble(b_out[4]),
    .W_bubble(b_out[3]), .set_CC(b_out[2]), .halted(b_out[1]), .mem_timeout(b_out[0]),
    .perf_loaduse(b_perf[15:12]), .perf_mispred(b_perf[11:8]),
    .perf_ret(b_perf[7:4]), .perf_memwait(b_perf[3:0])
  );

  typedef struct {
    logic [3:0]  d_icode, srca, srcb, e_icode, e_dstm;
    logic        cnd;
    logic [3:0]  m_icode;
    logic [2:0]  mstat, wstat;
    logic        busy;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int d, sa, sb, e, dm, c, m, ms, ws, b, input logic [11:0] ex);
    vec_t v;
    v.d_icode = 4'(d);  v.srca = 4'(sa);   v.srcb = 4'(sb);
    v.e_icode = 4'(e);  v.e_dstm = 4'(dm); v.cnd = c[0];
    v.m_icode = 4'(m);  v.mstat = 3'(ms);  v.wstat = 3'(ws);
    v.busy = b[0];      v.exp = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exc3(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd4);
  endfunction

  // Reference model: halt flag plus a count of cycles spent waiting on memory.
  function automatic void derive(output bit lu, mp, rt, memop, waiting, to, mex, wex);
    mex     = exc3(m_stat);
    wex     = exc3(W_stat);
    memop   = (M_icode == 4) || (M_icode == 5) || (M_icode >= 8 && M_icode <= 11);
    waiting = dmem_busy && ((mw > 0) || memop);
    to      = (mw == T_MAIN) && dmem_busy;
    lu      = (E_icode == 5 || E_icode == 11) && (E_dstM != 15) &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
    mp      = (E_icode == 7) && !e_Cnd;
    rt      = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
  endfunction

  function automatic logic [11:0] model_outs();
    bit lu, mp, rt, memop, waiting, to, mex, wex;
    bit fs, ds, db, eb, mb, ws, cc;
    if (!rst_n) return O_RESET;
    if (mh) return O_HALT;
    derive(lu, mp, rt, memop, waiting, to, mex, wex);
    if (waiting && !mex && !wex) return {O_MEMNR[11:1], to};
    fs = lu | rt;
    ds = lu;
    db = mp | (rt & !lu);
    eb = mp | lu;
    mb = mex | wex;
    ws = wex;
    cc = (E_icode == 6) && !mb;
    return {fs, ds, 1'b0, 1'b0, ws, db, eb, mb, 1'b0, cc, 1'b0, to};
  endfunction

  function automatic int sat_inc(input int c);
    return (c < PMAX) ? c + 1 : c;
  endfunction

  task automatic model_step();
    bit lu, mp, rt, memop, waiting, to, mex, wex;
    if (!rst_n) begin
      mh = 0; mw = 0; c_lu = 0; c_mp = 0; c_rt = 0; c_mw = 0;
    end else if (!mh) begin
      derive(lu, mp, rt, memop, waiting, to, mex, wex);
      if (lu) c_lu = sat_inc(c_lu);
      if (mp) c_mp = sat_inc(c_mp);
      if (rt && !lu && !(waiting && !mex && !wex)) c_rt = sat_inc(c_rt);
      if (waiting) c_mw = sat_inc(c_mw);
      if (wex || to)         mh = 1;
      else if (mw > 0)       mw = dmem_busy ? mw + 1 : 0;
      else if (memop && dmem_busy && !mex) mw = 1;
    end
  endtask

  task automatic model_check(input string name);
    logic [15:0] pexp;
`ifdef PIPE_PERF_CNT_EN
    pexp = {4'(c_lu), 4'(c_mp), 4'(c_rt), 4'(c_mw)};
`else
    pexp = '0;
`endif
    check({name, "_outs"}, {4'b0, a_out}, {4'b0, model_outs()});
    check({name, "_perf"}, a_perf, pexp);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic neutral();
    D_icode = 4'd0; d_srcA = 4'd1; d_srcB = 4'd2; E_icode = 4'd0; E_dstM = 4'd15;
    e_Cnd = 1'b0; M_icode = 4'd0; m_stat = 3'd1; W_stat = 3'd1; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    neutral();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 1, 2, 0, 15, 0, 0, 1, 1, 0, 12'b00000_0000_000);
    vecs[1]  = mk(0, 3, 2, 5, 3, 0, 0, 1, 1, 0, 12'b11000_0100_000);
    vecs[2]  = mk(0, 15, 15, 5, 15, 0, 0, 1, 1, 0, 12'b00000_0000_000);
    vecs[3]  = mk(0, 1, 2, 11, 2, 0, 0, 1, 1, 0, 12'b11000_0100_000);
    vecs[4]  = mk(0, 1, 2, 7, 15, 0, 0, 1, 1, 0, 12'b00000_1100_000);
    vecs[5]  = mk(0, 1, 2, 7, 15, 1, 0, 1, 1, 0, 12'b00000_0000_000);
    vecs[6]  = mk(9, 1, 2, 0, 15, 0, 0, 1, 1, 0, 12'b10000_1000_000);
    vecs[7]  = mk(9, 3, 2, 5, 3, 0, 0, 1, 1, 0, 12'b11000_0100_000);
    vecs[8]  = mk(0, 1, 2, 6, 15, 0, 0, 1, 1, 0, 12'b00000_0000_100);
    vecs[9]  = mk(0, 1, 2, 6, 15, 0, 0, 2, 1, 0, 12'b00000_0010_000);
    vecs[10] = mk(0, 1, 2, 0, 15, 0, 9, 1, 1, 0, 12'b10000_1000_000);
    vecs[11] = mk(0, 1, 2, 0, 15, 0, 5, 2, 1, 1, 12'b00000_0010_000);
    vecs[12] = mk(0, 1, 2, 0, 15, 0, 6, 1, 1, 1, 12'b00000_0000_000);
    vecs[13] = mk(9, 1, 2, 7, 15, 0, 0, 1, 1, 0, 12'b10000_1100_000);

    // Reset state of both instances
    neutral();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_a", {4'b0, a_out}, {4'b0, O_RESET});
    check("reset_b", {4'b0, b_out}, {4'b0, O_RESET});
    tick();
    rst_n = 1'b1;

    // Single-cycle hazard vectors from RUN
    for (int i = 0; i < 14; i++) begin
      D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
      E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_Cnd = vecs[i].cnd;
      M_icode = vecs[i].m_icode; m_stat = vecs[i].mstat; W_stat = vecs[i].wstat;
      dmem_busy = vecs[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d", i), {4'b0, a_out}, {4'b0, vecs[i].exp});
      tick();
    end

    // ret in Decode for three cycles, then with a load/use hazard
    do_reset();
    D_icode = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ret_cyc%0d", i), {4'b0, a_out}, {4'b0, 12'b10000_1000_000});
      tick();
    end
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    @(negedge clk);
    check("ret_lu", {4'b0, a_out}, {4'b0, 12'b11000_0100_000});
    tick();

    // mrmovq in M with dmem busy for four cycles
    do_reset();
    M_icode = 4'd5; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("memwait%0d", i), {4'b0, a_out}, {4'b0, O_MEMNR});
      model_check("memwait");
      tick();
    end
    dmem_busy = 1'b0;
    @(negedge clk);
    check("memwait_done", {4'b0, a_out}, 16'd0);
`ifdef PIPE_PERF_CNT_EN
    check("memwait_cnt", {12'b0, a_perf[3:0]}, 16'd4);
`else
    check("memwait_cnt", {12'b0, a_perf[3:0]}, 16'd0);
`endif
    tick();
    M_icode = 4'd0;

    // Watchdog on the short-timeout instance, then sticky halt, then reset
    do_reset();
    M_icode = 4'd5; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("to_cyc%0d", i), {4'b0, b_out},
            {4'b0, O_MEMNR[11:1], (i == 3) ? 1'b1 : 1'b0});
      model_check("to_main");
      tick();
    end
    @(negedge clk);
    check("to_halted", {4'b0, b_out}, {4'b0, O_HALT});
    tick();
    dmem_busy = 1'b0; M_icode = 4'd0;
    @(negedge clk);
    check("to_sticky", {4'b0, b_out}, {4'b0, O_HALT});
    model_check("to_main");
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("to_rst_b", {4'b0, b_out}, {4'b0, O_RESET});
    check("to_rst_a", {4'b0, a_out}, {4'b0, O_RESET});
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("to_run_b", {4'b0, b_out}, 16'd0);
    tick();

    // Memory-stage exception followed by writeback exception
    do_reset();
    E_icode = 4'd6; m_stat = 3'd2;
    @(negedge clk);
    check("exc_m", {4'b0, a_out}, {4'b0, 12'b00000_0010_000});
    tick();
    E_icode = 4'd0; m_stat = 3'd1; W_stat = 3'd2;
    @(negedge clk);
    check("exc_w", {4'b0, a_out}, {4'b0, 12'b00001_0010_000});
    tick();
    W_stat = 3'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("exc_halt%0d", i), {4'b0, a_out}, {4'b0, O_HALT});
      tick();
    end

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      rst_n     = ($urandom_range(0, 59) != 0);
      D_icode   = 4'($urandom_range(0, 11));
      E_icode   = 4'($urandom_range(0, 11));
      M_icode   = 4'($urandom_range(0, 11));
      r = $urandom_range(0, 4); d_srcA = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); d_srcB = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); E_dstM = (r == 4) ? 4'd15 : 4'(r);
      e_Cnd     = 1'($urandom_range(0, 1));
      m_stat    = ($urandom_range(0, 11) == 0)  ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat    = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      dmem_busy = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      model_check($sformatf("rnd%0d", n));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Next-generation pipeline control unit for the 5-stage Y86-64 pipeline.
- Keeps the classic hazard logic: load/use, mispredicted jXX, ret, exceptions.
- Adds a variable-latency data-memory wait state with a timeout watchdog.
- Adds a sticky halt state.
- Adds optional hazard performance counters.
- Sits beside the stage registers and drives their stall/bubble inputs.

Parameters:
ICODE_W, 4, width of icode fields
REG_W, 4, width of register IDs (RNONE = all ones)
STAT_W, 3, width of stat codes
MEM_TIMEOUT, 15, max consecutive dmem_busy cycles before timeout (1..255)
PERF_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
D_icode  in  ICODE_W  icode in the Decode register
d_srcA, d_srcB  in  REG_W  decode source registers
E_icode  in  ICODE_W  icode in the Execute register
E_dstM  in  REG_W  Execute-stage memory destination
e_Cnd  in  1  branch condition computed in Execute
M_icode  in  ICODE_W  icode in the Memory register
m_stat  in  STAT_W  Memory-stage status
W_stat  in  STAT_W  Writeback status
dmem_busy  in  1  data memory has not completed the M-stage access this cycle
F_stall, D_stall, E_stall, M_stall, W_stall  out  1  hold the stage register
D_bubble, E_bubble, M_bubble, W_bubble  out  1  load a nop/bubble into the stage register
set_CC  out  1  condition-code write enable
halted  out  1  pipeline frozen (sticky)
mem_timeout  out  1  one-cycle pulse when the watchdog fires
perf_loaduse, perf_mispred, perf_ret, perf_memwait  out  PERF_W  event counters

Behaviour:
- Shared constants (decimal codes):
  - icodes: IJXX=7, IOPQ=6, IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - stats: SAOK=1, SADR=2, SINS=3, SHLT=4.
  - exc(x) = x is SADR, SINS or SHLT.
- Outputs are combinational from the registered FSM state plus the current inputs.
- The FSM has three states: RUN, MEM_WAIT, HALT. It resets to RUN with wait_cnt=0.
- While rst_n=0:
  - D_bubble=E_bubble=M_bubble=W_bubble=1.
  - All other 1-bit outputs are 0.
  - Counters clear on that edge.
- memop = M_icode in {4,5,8,9,10,11}.
- Transitions, evaluated in priority order:
  - Any state, exc(W_stat) or mem_timeout -> HALT.
  - HALT -> HALT. It is left only by reset.
  - RUN, memop and dmem_busy and not exc(m_stat) -> MEM_WAIT. wait_cnt:=1.
  - MEM_WAIT:
    - dmem_busy=0 -> RUN.
    - Otherwise wait_cnt++.
    - mem_timeout=1 combinationally in the cycle where dmem_busy=1 and wait_cnt==MEM_TIMEOUT.
    - Next state is HALT.
- Output rules:
  - HALT:
    - halted=1.
    - All five stalls are 1.
    - All bubbles are 0.
    - set_CC=0.
  - Memory not ready: applies when the state is MEM_WAIT, or when the state is RUN with memop and dmem_busy.
    - F/D/E/M stall=1.
    - W_bubble=1.
    - D/E/M bubble=0.
    - set_CC=0.
    - The exception rules override this when exc(m_stat) or exc(W_stat).
  - Otherwise, classic rules:
    - lu = E_icode in {IMRMOVQ,IPOPQ} and E_dstM in {d_srcA,d_srcB} and E_dstM != RNONE.
    - mp = E_icode==IJXX and e_Cnd==0.
    - rt = IRET in any of D_icode, E_icode, M_icode.
    - F_stall = lu | rt.
    - D_stall = lu.
    - D_bubble = mp | (rt & ~lu).
    - E_bubble = mp | lu.
    - M_bubble = exc(m_stat) | exc(W_stat).
    - W_stall = exc(W_stat).
    - set_CC = (E_icode==IOPQ) & ~M_bubble.
    - E_stall = M_stall = W_bubble = 0.
- D_stall and D_bubble are never both 1. lu wins over rt.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - Each counter increments once per cycle its event is asserted: lu, mp, D_bubble caused by rt, memory-not-ready.
  - Counting happens in RUN/MEM_WAIT only, never in HALT.
  - Counters saturate at all ones.
- Undefined: all perf_* outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg holds the icode, stat, RNONE constants and the FSM state encoding.
- One sub-module, hazard_perf_counter, is a saturating PERF_W counter with an enable. It is instantiated 4 times under the macro.

Test Plan:
- mrmovq in E with E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With d_srcA=d_srcB=15 and E_dstM=15 -> no stall.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. Same with e_Cnd=1 -> all 0.
- D_icode=9 for 3 cycles -> F_stall=1, D_bubble=1 each cycle. Combined with a load/use hazard -> D_stall=1, D_bubble=0.
- M_icode=5, dmem_busy high 4 cycles -> F/D/E/M stall and W_bubble for 4 cycles, then RUN. With the macro, perf_memwait=4.
- dmem_busy held with MEM_TIMEOUT=3 -> mem_timeout pulses in the 3rd wait cycle, then halted=1 with all stalls held. rst_n=0 for one cycle -> RUN, D/E/M/W bubbles=1 during reset.
- m_stat=SADR with E_icode=6 -> M_bubble=1, set_CC=0. Next cycle W_stat=SADR -> W_stall=1, HALT entered.
